// File: rtl/tensor_loader_if.sv
// Handshake and data bundle for the tensor_loader parameter store.
// The master drives host/consumer-side controls and the slave is the loader itself.
interface tensor_loader_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 16
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(COLS);

  logic             write;
  logic [RW-1:0]    seli;
  logic [CW-1:0]    selj;
  logic [WIDTH-1:0] param_in;
  logic [WIDTH-1:0] param_out;
  logic             load_start;
  logic             loaded;
  logic             rd_row_req;
  logic [WIDTH-1:0] row_data;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;
  logic             busy;

  modport master (
    output write, seli, selj, param_in, load_start, rd_row_req, row_ready,
    input  param_out, loaded, row_data, row_valid, row_last, busy
  );

  modport slave (
    input  write, seli, selj, param_in, load_start, rd_row_req, row_ready,
    output param_out, loaded, row_data, row_valid, row_last, busy
  );
endinterface

// File: rtl/tensor_loader.sv
// ROWS x COLS parameter store with random access, auto-incrementing stream load
// and a valid/ready row-streaming read port.
module tensor_loader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 16
) (
  input logic            clk,
  input logic            reset,
  tensor_loader_if.slave bus
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic {LdIdle, LdLoad}   ld_state_e;
  typedef enum logic {StIdle, StStream} st_state_e;

  ld_state_e        ld_q, ld_d;
  st_state_e        st_q, st_d;
  logic [WIDTH-1:0] mem_q [ROWS][COLS];
  logic [RW-1:0]    ptr_i_q, ptr_i_d, row_q, row_d;
  logic [CW-1:0]    ptr_j_q, ptr_j_d, col_q, col_d, col_nxt;
  logic             loaded_q, loaded_d, busy_q, busy_d;
  logic             row_valid_q, row_valid_d, row_last_q, row_last_d;
  logic [WIDTH-1:0] row_data_q, row_data_d, param_out_q, param_out_d;
  logic             we, load_go;
  logic [RW-1:0]    wi;
  logic [CW-1:0]    wj;

  function automatic logic in_range(input logic [RW-1:0] i, input logic [CW-1:0] j);
    return (int'(i) < int'(ROWS)) && (int'(j) < int'(COLS));
  endfunction

  // Out-of-range cells read as zero.
  function automatic logic [WIDTH-1:0] elem(input logic [RW-1:0] i, input logic [CW-1:0] j);
    logic [WIDTH-1:0] v;
    v = '0;
    if (in_range(i, j)) v = mem_q[i][j];
    return v;
  endfunction

  assign col_nxt = col_q + CW'(1);

  always_comb begin
    ld_d        = ld_q;
    st_d        = st_q;
    ptr_i_d     = ptr_i_q;
    ptr_j_d     = ptr_j_q;
    loaded_d    = loaded_q;
    row_d       = row_q;
    col_d       = col_q;
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    row_last_d  = row_last_q;
    we          = 1'b0;
    wi          = bus.seli;
    wj          = bus.selj;
    load_go     = bus.load_start && (st_q == StIdle);
    param_out_d = elem(bus.seli, bus.selj);

    unique case (ld_q)
      LdIdle: begin
        if (bus.write && in_range(bus.seli, bus.selj)) we = 1'b1;
        if (load_go) begin
          ld_d     = LdLoad;
          ptr_i_d  = '0;
          ptr_j_d  = '0;
          loaded_d = 1'b0;
        end
      end
      LdLoad: begin
        if (load_go) begin
          ptr_i_d  = '0;
          ptr_j_d  = '0;
          loaded_d = 1'b0;
        end else if (bus.write) begin
          we = 1'b1;
          wi = ptr_i_q;
          wj = ptr_j_q;
          if (ptr_j_q == CW'(COLS - 1)) begin
            ptr_j_d = '0;
            if (ptr_i_q == RW'(ROWS - 1)) begin
              ptr_i_d  = '0;
              ld_d     = LdIdle;
              loaded_d = 1'b1;
            end else begin
              ptr_i_d = ptr_i_q + RW'(1);
            end
          end else begin
            ptr_j_d = ptr_j_q + CW'(1);
          end
        end
      end
      default: ld_d = LdIdle;
    endcase

    unique case (st_q)
      StIdle: begin
        // A simultaneous load_start (accepted here since the stream is idle) wins.
        if (bus.rd_row_req && (ld_q == LdIdle) && !bus.load_start) begin
          st_d        = StStream;
          row_d       = bus.seli;
          col_d       = '0;
          row_data_d  = elem(bus.seli, '0);
          row_valid_d = 1'b1;
          row_last_d  = 1'b0;
        end
      end
      StStream: begin
        if (row_valid_q && bus.row_ready) begin
          if (col_q == CW'(COLS - 1)) begin
            st_d        = StIdle;
            col_d       = '0;
            row_valid_d = 1'b0;
            row_last_d  = 1'b0;
          end else begin
            col_d      = col_nxt;
            row_data_d = elem(row_q, col_nxt);
            row_last_d = (col_nxt == CW'(COLS - 1));
          end
        end
      end
      default: st_d = StIdle;
    endcase

    busy_d = (ld_d == LdLoad) || (st_d == StStream);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q        <= LdIdle;
      st_q        <= StIdle;
      ptr_i_q     <= '0;
      ptr_j_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      row_data_q  <= '0;
      param_out_q <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      ld_q        <= ld_d;
      st_q        <= st_d;
      ptr_i_q     <= ptr_i_d;
      ptr_j_q     <= ptr_j_d;
      row_q       <= row_d;
      col_q       <= col_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
      row_data_q  <= row_data_d;
      param_out_q <= param_out_d;
      if (we) mem_q[wi][wj] <= bus.param_in;
    end
  end

  assign bus.param_out = param_out_q;
  assign bus.loaded    = loaded_q;
  assign bus.row_data  = row_data_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_last  = row_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_tensor_loader.sv
// Self-checking bench for tensor_loader: shadow array for random reads and a queue
// of expected row elements consumed as the stream port hands them over.
module tb_tensor_loader;
  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tensor_loader_if #(.WIDTH(W), .ROWS(R), .COLS(C)) bus ();

  tensor_loader #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [W-1:0] model [R][C];
  logic [W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) model[r][c] = '0;
  endtask

  task automatic rd_chk(input string tag, input int i, input int j);
    bus.write = 1'b0;
    bus.seli  = 2'(i);
    bus.selj  = 4'(j);
    tick();
    check_eq(tag, 32'(bus.param_out), 32'(model[i][j]));
  endtask

  // Stream-load element k = index value; gaps drop write every 3rd cycle and
  // poke rd_row_req, which must be ignored while loading.
  task automatic do_load(input bit gaps, input int nwrites);
    int k;
    int cyc;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check_eq("busy_in_load", 32'(bus.busy), 32'd1);
    k = 0;
    cyc = 0;
    while (k < nwrites && cyc < 300) begin
      if (gaps && (cyc % 3 == 2)) begin
        bus.write      = 1'b0;
        bus.rd_row_req = 1'b1;
        bus.seli       = 2'd2;
        tick();
        check_eq("rd_req_in_load_ignored", 32'(bus.row_valid), 32'd0);
      end else begin
        bus.rd_row_req = 1'b0;
        bus.write      = 1'b1;
        bus.seli       = 2'd0;
        bus.selj       = 4'd0;
        bus.param_in   = 16'(k);
        model[k / C][k % C] = 16'(k);
        tick();
        k++;
        check_eq($sformatf("loaded_after_%0d", k), 32'(bus.loaded), 32'(k == R * C));
      end
      cyc++;
    end
    bus.write      = 1'b0;
    bus.rd_row_req = 1'b0;
    check_eq("load_write_count", 32'(k), 32'(nwrites));
  endtask

  // ready_pat bit (cycle % 4) drives row_ready; exp_cycles is the cycle count to drain.
  task automatic stream_row(input int row, input logic [3:0] ready_pat, input int exp_cycles);
    int cyc;
    int idx;
    bit stalled;
    logic [W-1:0] hold_data;
    logic hold_last;
    logic [W-1:0] e;
    bus.seli       = 2'(row);
    bus.rd_row_req = 1'b1;
    tick();
    bus.rd_row_req = 1'b0;
    for (int c = 0; c < C; c++) exp_q.push_back(model[row][c]);
    cyc = 0;
    stalled = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      bus.row_ready = ready_pat[cyc % 4];
      if (bus.row_valid !== 1'b1) check_eq("row_valid_during_row", 32'(bus.row_valid), 32'd1);
      if (stalled) begin
        check_eq("stall_hold_data", 32'(bus.row_data), 32'(hold_data));
        check_eq("stall_hold_last", 32'(bus.row_last), 32'(hold_last));
      end
      if (bus.row_valid && bus.row_ready) begin
        idx = C - exp_q.size();
        e = exp_q.pop_front();
        check_eq($sformatf("row%0d_elem%0d", row, idx), 32'(bus.row_data), 32'(e));
        check_eq($sformatf("row%0d_last%0d", row, idx), 32'(bus.row_last), 32'(idx == C - 1));
        stalled = 1'b0;
      end else if (bus.row_valid) begin
        stalled = 1'b1;
        hold_data = bus.row_data;
        hold_last = bus.row_last;
      end
      tick();
      cyc++;
    end
    bus.row_ready = 1'b0;
    check_eq("stream_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_eq("stream_cycles", 32'(cyc), 32'(exp_cycles));
    check_eq("row_valid_after", 32'(bus.row_valid), 32'd0);
    check_eq("busy_after_stream", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.write      = 1'b0;
    bus.seli       = '0;
    bus.selj       = '0;
    bus.param_in   = '0;
    bus.load_start = 1'b0;
    bus.rd_row_req = 1'b0;
    bus.row_ready  = 1'b0;
    clear_model();
    #1 reset = 1'b1;
    tick();
    tick();
    check_eq("rst_param_out", 32'(bus.param_out), 32'd0);
    check_eq("rst_loaded", 32'(bus.loaded), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_row_valid", 32'(bus.row_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Random write; a read of the same cell on the write edge returns the old value.
    bus.write    = 1'b1;
    bus.seli     = 2'd1;
    bus.selj     = 4'd3;
    bus.param_in = 16'hDEAD;
    tick();
    check_eq("same_cycle_read_old", 32'(bus.param_out), 32'd0);
    model[1][3] = 16'hDEAD;
    rd_chk("rd_1_3", 1, 3);
    rd_chk("rd_1_2", 1, 2);

    do_load(1'b0, R * C);
    check_eq("busy_after_load", 32'(bus.busy), 32'd0);
    rd_chk("rd_2_5", 2, 5);
    rd_chk("rd_3_15", 3, 15);
    rd_chk("rd_1_3_overwritten", 1, 3);

    do_load(1'b1, R * C);
    rd_chk("gap_rd_2_5", 2, 5);
    rd_chk("gap_rd_0_7", 0, 7);

    stream_row(2, 4'b1111, C);
    stream_row(1, 4'b1001, 2 * C);

    // Reset in the middle of a row stream.
    bus.seli       = 2'd3;
    bus.rd_row_req = 1'b1;
    tick();
    bus.rd_row_req = 1'b0;
    bus.row_ready  = 1'b1;
    tick();
    tick();
    bus.row_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_strm_row_valid", 32'(bus.row_valid), 32'd0);
    check_eq("rst_strm_row_data", 32'(bus.row_data), 32'd0);
    check_eq("rst_strm_row_last", 32'(bus.row_last), 32'd0);
    check_eq("rst_strm_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_strm_loaded", 32'(bus.loaded), 32'd0);
    clear_model();
    tick();
    reset = 1'b0;
    rd_chk("rst_strm_rd_2_5", 2, 5);
    rd_chk("rst_strm_rd_3_15", 3, 15);

    // Reset after 10 stream-load writes.
    do_load(1'b0, 10);
    reset = 1'b1;
    #1;
    check_eq("rst_load_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_load_loaded", 32'(bus.loaded), 32'd0);
    check_eq("rst_load_param_out", 32'(bus.param_out), 32'd0);
    clear_model();
    tick();
    reset = 1'b0;
    rd_chk("rst_load_rd_0_0", 0, 0);
    rd_chk("rst_load_rd_0_9", 0, 9);

    // After the aborted load a stream must be accepted again and return zeros.
    stream_row(0, 4'b1111, C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
